// File: rtl/countdown_timer_if.sv
// Control/status bundle between a host and countdown_timer.
// The psc field exists only when COUNTDOWN_TIMER_PRESCALE_EN is defined.
interface countdown_timer_if #(
    parameter int DW    = 16,
    parameter int PSC_W = 8
);
    logic          start;
    logic          stop;
    logic          en;
    logic          periodic;
    logic [DW-1:0] load_val;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc;
`else
    // PSC_W only sizes psc; keep it referenced so the default build stays lint-quiet
    logic unused_psc_w;
    assign unused_psc_w = ^PSC_W;
`endif
    logic [DW-1:0] cnt;
    logic          busy;
    logic          tick;
    logic          done;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    modport master (output start, stop, en, periodic, load_val, psc,
                    input  cnt, busy, tick, done);
    modport slave  (input  start, stop, en, periodic, load_val, psc,
                    output cnt, busy, tick, done);
`else
    modport master (output start, stop, en, periodic, load_val,
                    input  cnt, busy, tick, done);
    modport slave  (input  start, stop, en, periodic, load_val,
                    output cnt, busy, tick, done);
`endif
endinterface

// File: rtl/countdown_timer.sv
// One-shot / auto-reload down counter with terminal-count tick and sticky done.
// Optional prescaler enabled by defining COUNTDOWN_TIMER_PRESCALE_EN.
module countdown_timer #(
    parameter int DW    = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    countdown_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [DW-1:0] cnt;
    logic [DW-1:0] reload;
    logic          mode;
    logic          done;
    logic          step;
    logic          tick;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    logic [PSC_W-1:0] prescaler;

    assign step = (prescaler == bus.psc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (bus.stop || bus.start) begin
            prescaler <= '0;
        end else if (bus.en && state == RUN) begin
            prescaler <= step ? '0 : prescaler + PSC_W'(1);
        end
    end
`else
    logic unused_psc_w;
    assign unused_psc_w = ^PSC_W;
    assign step = 1'b1;
`endif

    assign tick = bus.en && (state == RUN) && (cnt == '0) && step;

    // stop beats start, start beats the terminal-count action (so a retrigger never sets done)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            reload <= '0;
            mode   <= 1'b0;
            done   <= 1'b0;
        end else if (bus.stop) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (bus.start) begin
            state  <= RUN;
            cnt    <= bus.load_val;
            reload <= bus.load_val;
            mode   <= bus.periodic;
            done   <= 1'b0;
        end else if (tick) begin
            if (mode) begin
                cnt <= reload;
            end else begin
                state <= IDLE;
                done  <= 1'b1;
            end
        end else if (state == RUN && bus.en && step) begin
            cnt <= cnt - DW'(1);
        end
    end

    assign bus.cnt  = cnt;
    assign bus.busy = (state == RUN);
    assign bus.tick = tick;
    assign bus.done = done;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer, checked against a step-level model.
// Prescale scenario is included when COUNTDOWN_TIMER_PRESCALE_EN is defined.
module tb_countdown_timer;
    localparam int DW    = 16;
    localparam int PSC_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    countdown_timer_if #(.DW(DW), .PSC_W(PSC_W)) bus ();
    countdown_timer #(.DW(DW), .PSC_W(PSC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int compared   = 0;
    int mismatched = 0;

    // Reference model: remaining steps, latched reload/mode, sub-step phase
    bit m_busy, m_periodic, m_done, exp_tick;
    int m_left, m_reload, m_phase, psc_val;
    logic last_tick;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        last_tick = bus.tick;
        check({tag, "_cnt"},  32'(bus.cnt),  32'(m_left));
        check({tag, "_busy"}, 32'(bus.busy), 32'(m_busy));
        check({tag, "_tick"}, 32'(bus.tick), 32'(exp_tick));
        check({tag, "_done"}, 32'(bus.done), 32'(m_done));
    endtask

    task automatic modelReset();
        m_busy = 0; m_periodic = 0; m_done = 0;
        m_left = 0; m_reload = 0; m_phase = 0;
    endtask

    // One clock cycle: drive at negedge, compare, advance model, wait for posedge
    task automatic applyStimulus(input string tag, input bit st, input bit sp, input bit e,
                                 input bit per, input int lv);
        @(negedge clk);
        bus.start    = st;
        bus.stop     = sp;
        bus.en       = e;
        bus.periodic = per;
        bus.load_val = DW'(lv);
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
        bus.psc      = PSC_W'(psc_val);
`endif
        #1;
        exp_tick = m_busy && e && (m_left == 0) && (m_phase == psc_val);
        checkOutput(tag);
        if (sp) begin
            m_busy = 0; m_left = 0; m_done = 0; m_phase = 0;
        end else if (st) begin
            m_busy = 1; m_left = lv; m_reload = lv; m_periodic = per; m_done = 0; m_phase = 0;
        end else if (m_busy && e) begin
            if (m_phase < psc_val) begin
                m_phase++;
            end else begin
                m_phase = 0;
                if (m_left > 0) m_left--;
                else if (m_periodic) m_left = m_reload;
                else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        exp_tick = 0;
        checkOutput(tag);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.en = 0; bus.periodic = 0; bus.load_val = '0;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
        bus.psc = '0;
`endif
        psc_val = 0;
        modelReset();
        applyReset("reset");

        // One-shot from 3: tick on the 4th RUN cycle, then idle with done
        applyStimulus("os_start", 1, 0, 1, 0, 3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("os_run", 0, 0, 1, 0, 3);
            check("os_tick_pos", 32'(last_tick), 32'(i == 3));
        end
        #1;
        check("os_end_busy", 32'(bus.busy), 32'd0);
        check("os_end_done", 32'(bus.done), 32'd1);
        check("os_end_cnt",  32'(bus.cnt),  32'd0);

        // Periodic from 2: ticks on cycles 3, 6, 9
        applyStimulus("per_start", 1, 0, 1, 1, 2);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus("per_run", 0, 0, 1, 0, 7);
            check("per_tick_pos", 32'(last_tick), 32'(i % 3 == 0));
        end
        #1;
        check("per_reload", 32'(bus.cnt), 32'd2);
        applyStimulus("per_stop", 0, 1, 1, 1, 2);

        // Enable gaps: single tick on the third enabled cycle
        applyStimulus("gap_start", 1, 0, 1, 0, 2);
        applyStimulus("gap_e1", 0, 0, 1, 0, 2);
        applyStimulus("gap_e0", 0, 0, 0, 0, 2);
        applyStimulus("gap_e1", 0, 0, 1, 0, 2);
        applyStimulus("gap_e0", 0, 0, 0, 0, 2);
        check("gap_no_tick", 32'(last_tick), 32'd0);
        applyStimulus("gap_e1", 0, 0, 1, 0, 2);
        check("gap_tick", 32'(last_tick), 32'd1);

        // start+stop together lands in IDLE with cnt cleared
        applyStimulus("pri_start", 1, 0, 1, 0, 4);
        applyStimulus("pri_run", 0, 0, 1, 0, 4);
        applyStimulus("pri_both", 1, 1, 1, 0, 9);
        #1;
        check("pri_both_busy", 32'(bus.busy), 32'd0);
        check("pri_both_cnt",  32'(bus.cnt),  32'd0);

        // Retrigger in the tick cycle: tick still fires, start wins
        applyStimulus("rt_start", 1, 0, 1, 0, 1);
        applyStimulus("rt_run", 0, 0, 1, 0, 1);
        applyStimulus("rt_tick", 1, 0, 1, 0, 5);
        check("rt_tick_seen", 32'(last_tick), 32'd1);
        #1;
        check("rt_cnt",  32'(bus.cnt),  32'd5);
        check("rt_busy", 32'(bus.busy), 32'd1);
        check("rt_done", 32'(bus.done), 32'd0);
        applyStimulus("rt_stop", 0, 1, 0, 0, 0);

        // Reset at cnt=4 mid-run, then no tick without a new start
        applyStimulus("rst_start", 1, 0, 1, 0, 6);
        applyStimulus("rst_run", 0, 0, 1, 0, 6);
        applyStimulus("rst_run", 0, 0, 1, 0, 6);
        #1;
        check("rst_pre_cnt", 32'(bus.cnt), 32'd4);
        applyReset("rst_mid");
        for (int i = 0; i < 5; i++) applyStimulus("rst_after", 0, 0, 1, i % 2, 0);

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
        // Prescale by 4: one-shot from 1 ticks on enabled cycle 8
        psc_val = 3;
        applyStimulus("psc_start", 1, 0, 1, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus("psc_run", 0, 0, 1, 0, 1);
            check("psc_tick_pos", 32'(last_tick), 32'(i == 8));
        end
        applyStimulus("psc_stop", 0, 1, 0, 0, 0);
        psc_val = $urandom_range(0, 2);
`endif

        // Randomized traffic; load_val and periodic wander freely during RUN
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the counter width in bits.
REQ-002 The block SHALL have parameter PSC_W, default 8, giving the prescaler width; it is used only when COUNTDOWN_TIMER_PRESCALE_EN is defined.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-004 Port clk SHALL be an input, 1 bit wide: the clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: the asynchronous, active-high reset.
REQ-006 Port start SHALL be an input, 1 bit wide: a single-cycle request to load load_val and run.
REQ-007 Port stop SHALL be an input, 1 bit wide: abort; return to IDLE.
REQ-008 Port en SHALL be an input, 1 bit wide: count enable; gates every decrement and tick.
REQ-009 Port periodic SHALL be an input, 1 bit wide: 1 selects auto-reload, 0 selects one-shot; sampled together with start.
REQ-010 Port load_val SHALL be an input, DW bits wide: the initial and reload count.
REQ-011 Port psc SHALL be an input, PSC_W bits wide: the prescale divisor minus 1; it is present only with the macro defined.
REQ-012 Port cnt SHALL be an output, DW bits wide: the current remaining count.
REQ-013 Port busy SHALL be an output, 1 bit wide: high while the FSM is in RUN.
REQ-014 Port tick SHALL be an output, 1 bit wide: terminal-count pulse.
REQ-015 Port done SHALL be an output, 1 bit wide: sticky flag marking one-shot completion.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and RUN. busy SHALL equal (state == RUN).
REQ-017 At each clock edge, priority SHALL be stop > start > counting.
REQ-018 stop=1 SHALL set state IDLE and cnt=0 at the next edge, clear done, and apply regardless of start and en.
REQ-019 start=1 with stop=0, in any state, SHALL load cnt=load_val, latch reload=load_val and mode=periodic, clear done, and set state RUN at the next edge; a start during RUN retriggers.
REQ-020 In RUN with en=1 and cnt>0, cnt SHALL decrement by 1 per step.
REQ-021 tick SHALL be combinational and equal en & (state==RUN) & (cnt==0) & step; step is 1 without the macro.
REQ-022 When tick=1 and mode=periodic, the next edge SHALL set cnt=reload and keep state RUN; the tick period SHALL be reload+1 steps.
REQ-023 When tick=1 and mode is one-shot, the next edge SHALL set state IDLE, keep cnt=0, and set done=1.
REQ-024 When start and tick coincide, start SHALL win the next-state decision; tick SHALL still assert in that cycle and done SHALL NOT set.
REQ-025 load_val=0 SHALL be legal: after start, the first enabled step ticks; periodic mode then ticks on every step.
REQ-026 en=0 SHALL freeze cnt and the prescaler, and tick SHALL be 0.
REQ-027 In IDLE, cnt SHALL hold its value, tick SHALL be 0, and en SHALL be ignored.
REQ-028 A change of load_val or periodic during RUN SHALL have no effect until the next start.

Reset
REQ-029 While rst=1, the block SHALL immediately set state=IDLE, cnt=0, reload=0, mode=0, done=0, and prescaler=0, so busy=0 and tick=0.
REQ-030 Assertion of rst mid-count SHALL abort the count, and no tick SHALL occur until a new start after rst deasserts.

Configuration
REQ-031 With COUNTDOWN_TIMER_PRESCALE_EN defined, the block SHALL contain a PSC_W-bit prescaler that increments on en in RUN, wraps at psc, and sets step=(prescaler==psc); the prescaler SHALL clear on start, stop, and reset.
REQ-032 With COUNTDOWN_TIMER_PRESCALE_EN defined, every step SHALL take psc+1 enabled cycles, and psc SHALL be sampled continuously.
REQ-033 With COUNTDOWN_TIMER_PRESCALE_EN undefined, the psc port and the prescaler logic SHALL be absent, and step SHALL be 1.

Verification
REQ-034 The bench SHALL cover one-shot: load_val=3, periodic=0, en=1 -> cnt 3,2,1,0, tick for 1 cycle on the 4th RUN cycle, then busy=0 and done=1.
REQ-035 The bench SHALL cover periodic: load_val=2, periodic=1, en=1 for 9 cycles -> tick on cycles 3, 6, and 9 with cnt reloaded to 2 after each tick.
REQ-036 The bench SHALL cover en gaps: load_val=2 with en toggling 1,0,1,0,1 -> a single tick on the 3rd enabled cycle and cnt frozen during en=0.
REQ-037 The bench SHALL cover priority: start and stop together -> IDLE with cnt=0; start in the tick cycle with load_val=5 -> tick=1, next cnt=5, busy=1, done=0.
REQ-038 The bench SHALL cover reset: rst pulsed at cnt=4 mid-RUN -> cnt=0, busy=0, done=0 immediately, and no tick before the next start.
REQ-039 With the macro defined, the bench SHALL cover prescale: psc=3, load_val=1, one-shot -> tick on enabled cycle 8, and cnt changes only every 4 cycles.
